// File: rtl/svpwm_gen.sv
// Three-phase centre-aligned SVPWM generator: min-max zero-sequence injection, valley-loaded compares.
// Optional dead-time insertion is enabled by defining SVPWM_DEADTIME_EN.

module svpwm_gen_phase #(
  parameter logic [15:0] PERIOD   = 16'd2500,
  parameter logic [7:0]  DEADTIME = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] cnt_i,
  input  logic [15:0] cmp_i,
  output logic [1:0]  gate_o
);
  logic       hit;
  logic [1:0] s_d, s_q, gate_d, gate_q;
  logic [7:0] dt_d, dt_q;

  assign hit    = (cmp_i >= PERIOD) || (cnt_i < cmp_i);
  assign s_d    = !en_i ? 2'b00 : (hit ? 2'b10 : 2'b01);
  // Any change of wanted state restarts the blanking window; both gates stay off until it expires.
  assign dt_d   = (s_d != s_q) ? 8'd0 : ((dt_q == DEADTIME) ? dt_q : dt_q + 8'd1);
  assign gate_d = (dt_d == DEADTIME) ? s_d : 2'b00;
  assign gate_o = gate_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 2'b00;
      dt_q   <= 8'd0;
      gate_q <= 2'b00;
    end else begin
      s_q    <= s_d;
      dt_q   <= dt_d;
      gate_q <= gate_d;
    end
  end
endmodule

module svpwm_gen #(
  parameter logic [15:0] PERIOD   = 16'd2500,
  parameter logic [7:0]  DEADTIME = 8'd20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [63:0] s_axis,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        pwm_ah,
  output logic        pwm_bh,
  output logic        pwm_ch,
  output logic        pwm_al,
  output logic        pwm_bl,
  output logic        pwm_cl,
  output logic        pwm_sync
);
  localparam int NUM_PH = 3;
  localparam int STAGES = 1;
`ifdef SVPWM_DEADTIME_EN
  localparam logic [7:0] DT_LEN = DEADTIME;
`else
  localparam logic [7:0] DT_LEN = DEADTIME & 8'h00;
`endif

  logic [15:0]              cnt_q, cnt_d;
  logic                     up_q, up_d;
  logic [STAGES:0]          vld_pipe;
  logic [NUM_PH-1:0][15:0]  v1_q, v2_q, cmp_s3, pend_q, cmp_q;
  logic signed [15:0]       vmax_d, vmin_d, vmax_q, vmin_q;
  logic signed [17:0]       vsum, voff;
  logic                     pend_vld_q, sync_q, acc, valley;
  logic [NUM_PH-1:0][1:0]   gate;
  logic                     unused_theta;

  assign unused_theta  = ^s_axis[63:48];
  assign s_axis_tready = ~(|vld_pipe | pend_vld_q);
  assign acc           = s_axis_tvalid & s_axis_tready & enable;
  assign valley        = enable & (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (!enable) begin
      cnt_d = 16'd0;
      up_d  = 1'b1;
    end else if (up_q) begin
      cnt_d = cnt_q + 16'd1;
      up_d  = (cnt_d != PERIOD);
    end else begin
      cnt_d = cnt_q - 16'd1;
      up_d  = (cnt_d == 16'd0);
    end
  end

  always_comb begin
    vmax_d = $signed(v1_q[0]);
    vmin_d = $signed(v1_q[0]);
    for (int i = 1; i < NUM_PH; i++) begin
      if ($signed(v1_q[i]) > vmax_d) vmax_d = $signed(v1_q[i]);
      if ($signed(v1_q[i]) < vmin_d) vmin_d = $signed(v1_q[i]);
    end
  end

  // 18-bit sum so that negating -65536 cannot overflow before the halving.
  assign vsum = {{2{vmax_q[15]}}, vmax_q} + {{2{vmin_q[15]}}, vmin_q};
  assign voff = (-vsum) >>> 1;

  for (genvar g = 0; g < NUM_PH; g++) begin : g_lane
    logic signed [17:0] vp;
    logic [15:0]        sat, u;
    assign vp = $signed({{2{v2_q[g][15]}}, v2_q[g]}) + voff;
    always_comb begin
      if (vp > 18'sd32767)       sat = 16'h7fff;
      else if (vp < -18'sd32768) sat = 16'h8000;
      else                       sat = vp[15:0];
    end
    assign u         = {~sat[15], sat[14:0]};
    assign cmp_s3[g] = 16'((32'(u) * 32'(PERIOD)) >> 16);

    svpwm_gen_phase #(.PERIOD(PERIOD), .DEADTIME(DT_LEN)) u_phase (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (enable),
      .cnt_i  (cnt_q),
      .cmp_i  (cmp_q[g]),
      .gate_o (gate[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 16'd0;
      up_q       <= 1'b1;
      vld_pipe   <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      vmax_q     <= '0;
      vmin_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cmp_q      <= {NUM_PH{PERIOD >> 1}};
      sync_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      vld_pipe <= enable ? {vld_pipe[STAGES-1:0], acc} : '0;
      if (acc) v1_q <= s_axis[47:0];
      if (vld_pipe[0]) begin
        v2_q   <= v1_q;
        vmax_q <= vmax_d;
        vmin_q <= vmin_d;
      end
      if (vld_pipe[STAGES]) pend_q <= cmp_s3;
      // A result landing on the valley edge is held until the following valley.
      if (!enable)               pend_vld_q <= 1'b0;
      else if (vld_pipe[STAGES]) pend_vld_q <= 1'b1;
      else if (valley)           pend_vld_q <= 1'b0;
      if (valley && pend_vld_q) cmp_q <= pend_q;
      sync_q <= valley;
    end
  end

  assign {pwm_ah, pwm_al} = gate[0];
  assign {pwm_bh, pwm_bl} = gate[1];
  assign {pwm_ch, pwm_cl} = gate[2];
  assign pwm_sync         = sync_q;
endmodule
